// File: rtl/varint_pkg.sv
// varint_pkg: shared constants and the length type for the varint serializer
package varint_pkg;
  localparam int BYTE = 8;
  localparam int IN_BYTES = 8;
  localparam int MAX_VARINT_BYTES = 10;
  localparam int IN_W = IN_BYTES * BYTE;
  localparam int OUT_W = MAX_VARINT_BYTES * BYTE;
  typedef logic [3:0] len_t;
endpackage

// File: rtl/varint_len.sv
// varint_len: byte count of the LEB128 encoding of a 64-bit value
//   val_i  value to be encoded
//   len_o  encoded length, 1..10
module varint_len
  import varint_pkg::*;
(
  input  logic [IN_W-1:0] val_i,
  output len_t            len_o
);
  // The highest non-empty 7-bit group decides the length; zero still needs one byte.
  always_comb begin
    len_o = len_t'(1);
    for (int k = 1; k < MAX_VARINT_BYTES; k++)
      if (|(val_i >> (7 * k))) len_o = len_t'(k + 1);
  end
endmodule

// File: rtl/varint_ser.sv
// varint_ser: one-cycle protobuf base-128 varint encoder
//   clk, rst_n          clock, async active-low reset
//   in_valid, in_port   64-bit value to encode this cycle
//   out_valid           registered encoding valid
//   out_port, out_len   encoded bytes (byte 0 in [7:0]) and their count
module varint_ser
  import varint_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_port,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_port,
  output len_t             out_len
);
  localparam int PAD_W = 7 * MAX_VARINT_BYTES;
  len_t             len;
  logic [PAD_W-1:0] pad;
  logic [OUT_W-1:0] enc;
  logic             valid_q;
  logic [OUT_W-1:0] port_q, port_d;
  len_t             len_q, len_d;
  varint_len u_len (.val_i(in_port), .len_o(len));
  // Zero-extending to 70 bits leaves byte 9 with only bit 63 and empty groups
  // above the length, so padding bytes fall out as 0x00 without masking.
  always_comb begin
    pad = {{(PAD_W - IN_W){1'b0}}, in_port};
    enc = '0;
    for (int k = 0; k < MAX_VARINT_BYTES; k++)
      enc[BYTE*k +: BYTE] = {(k + 1) < int'(len), pad[7*k +: 7]};
    port_d = in_valid ? enc : port_q;
    len_d  = in_valid ? len : len_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      port_q  <= '0;
      len_q   <= '0;
    end else begin
      valid_q <= in_valid;
      port_q  <= port_d;
      len_q   <= len_d;
    end
  assign out_valid = valid_q;
  assign out_port  = port_q;
  assign out_len   = len_q;
endmodule

// File: tb/tb_varint_ser.sv
// tb_varint_ser: directed and random checks of the varint serializer
module tb_varint_ser;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_port = '0;
  logic        out_valid;
  logic [79:0] out_port;
  logic [3:0]  out_len;
  int          n_chk = 0;
  int          n_pass = 0;
  varint_ser dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_port(in_port),
    .out_valid(out_valid), .out_port(out_port), .out_len(out_len)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step(input logic v, input logic [63:0] d);
    @(negedge clk);
    in_valid = v;
    in_port  = d;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string tag, input logic [79:0] p, input int l);
    check({tag, " valid"}, 80'(out_valid), 80'd1);
    check({tag, " port"}, out_port, p);
    check({tag, " len"}, 80'(out_len), 80'(l));
  endtask
  function automatic logic [79:0] leb(input logic [63:0] v, output int n);
    logic [79:0] r;
    logic [63:0] t;
    r = '0;
    t = v;
    n = 0;
    do begin
      r[8*n +: 8] = {(t >> 7) != 0, t[6:0]};
      t = t >> 7;
      n++;
    end while (t != 0);
    return r;
  endfunction
  initial begin
    logic [63:0] v;
    logic [79:0] e;
    int          n;
    #3;
    check("rst valid", 80'(out_valid), 80'd0);
    check("rst port", out_port, 80'd0);
    check("rst len", 80'(out_len), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 64'd150);                 expect_out("150", 80'h0196, 2);
    step(1'b1, 64'd0);                   expect_out("0", 80'h00, 1);
    step(1'b1, 64'd127);                 expect_out("127", 80'h7F, 1);
    step(1'b1, 64'd128);                 expect_out("128", 80'h0180, 2);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF); expect_out("max", 80'h01FF_FFFF_FFFF_FFFF_FFFF, 10);
    step(1'b1, 64'h8000_0000_0000_0000); expect_out("msb", 80'h0180_8080_8080_8080_8080, 10);
    step(1'b1, 64'd300);                 expect_out("300", 80'h02AC, 2);
    step(1'b1, 64'd16383);               expect_out("16383", 80'h7FFF, 2);
    step(1'b1, 64'd16384);               expect_out("16384", 80'h018080, 3);
    step(1'b0, 64'd5);
    check("idle valid", 80'(out_valid), 80'd0);
    check("idle port", out_port, 80'h018080);
    check("idle len", 80'(out_len), 80'd3);
    step(1'b1, 64'd150);                 expect_out("pre-rst", 80'h0196, 2);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("async valid", 80'(out_valid), 80'd0);
    check("async port", out_port, 80'd0);
    check("async len", 80'(out_len), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-rst valid", 80'(out_valid), 80'd0);
    for (int i = 0; i < 24; i++) begin
      v = {$urandom, $urandom} >> $urandom_range(63, 0);
      e = leb(v, n);
      step(1'b1, v);
      expect_out("rand", e, n);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
